// File: rtl/can_bit_sampler.sv
// CAN RX front end: sync, hard-sync on SOF, 3-point majority sampling, destuffing.
// Define CAN_STUFF_ERR_EN to add the stuffErr port, which flags dominant stuff violations.
module can_bit_sampler #(
  parameter int TQ_PRESCALE = 4,
  parameter int BIT_TQ      = 16,
  parameter int SAMPLE_TQ   = 11,
  parameter int IDLE_BITS   = 11
) (
  input  logic clk,
  input  logic resetN,
  input  logic rxIn,
  output logic dOut,
  output logic samplePulse,
  output logic frameActive,
  output logic bitValid,
  output logic busIdle
`ifdef CAN_STUFF_ERR_EN
  ,
  output logic stuffErr
`endif
);

  localparam int PRE_W  = (TQ_PRESCALE > 1) ? $clog2(TQ_PRESCALE) : 1;
  localparam int TQ_W   = (BIT_TQ > 1) ? $clog2(BIT_TQ) : 1;
  localparam int IDLE_W = $clog2(IDLE_BITS + 1);

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TQ_PRESCALE - 1);
  localparam logic [TQ_W-1:0]   TQ_LAST   = TQ_W'(BIT_TQ - 1);
  localparam logic [TQ_W-1:0]   TQ_S0     = TQ_W'(SAMPLE_TQ - 1);
  localparam logic [TQ_W-1:0]   TQ_S1     = TQ_W'(SAMPLE_TQ);
  localparam logic [TQ_W-1:0]   TQ_S2     = TQ_W'(SAMPLE_TQ + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_BITS - 1);

  typedef enum logic [1:0] {
    S_INTEGRATE,
    S_IDLE,
    S_ACTIVE
  } state_t;

  state_t             state_reg, state_next;
  logic [IDLE_W-1:0]  idle_cnt_reg, idle_cnt_next;
  logic               rx_meta, rx_s, rx_prev;
  logic [PRE_W-1:0]   pre_cnt;
  logic [TQ_W-1:0]    tq_cnt;
  logic               s0, s1;
  logic               run_val;
  logic [2:0]         run_len;
  logic               dout_reg, bit_valid_reg;

  logic pre_zero, at_s0, at_s1, at_s2;
  logic fall_edge, bit_val, is_stuff, violation;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxIn;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign pre_zero  = (pre_cnt == '0);
  assign at_s0     = pre_zero && (tq_cnt == TQ_S0);
  assign at_s1     = pre_zero && (tq_cnt == TQ_S1);
  assign at_s2     = pre_zero && (tq_cnt == TQ_S2);
  assign fall_edge = rx_prev & ~rx_s;
  // Third sample is taken live so the vote is ready in the same cycle.
  assign bit_val   = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign is_stuff  = (run_len == 3'd5);
  assign violation = (state_reg == S_ACTIVE) && at_s2 && is_stuff && (bit_val == run_val);

  always_ff @(posedge clk) begin
    if (!resetN || state_reg == S_IDLE) begin
      pre_cnt <= '0;
      tq_cnt  <= '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
      tq_cnt  <= (tq_cnt == TQ_LAST) ? '0 : tq_cnt + 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      if (at_s0) s0 <= rx_s;
      if (at_s1) s1 <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_reg    <= S_INTEGRATE;
      idle_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      idle_cnt_reg <= idle_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    idle_cnt_next = idle_cnt_reg;
    case (state_reg)
      S_INTEGRATE: begin
        if (at_s2) begin
          if (!bit_val) begin
            idle_cnt_next = '0;
          end else if (idle_cnt_reg == IDLE_LAST) begin
            idle_cnt_next = '0;
            state_next    = S_IDLE;
          end else begin
            idle_cnt_next = idle_cnt_reg + 1'b1;
          end
        end
      end
      S_IDLE: begin
        if (fall_edge) state_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        // A recessive violation is the normal end of frame and counts toward idle.
        if (violation) begin
          state_next    = S_INTEGRATE;
          idle_cnt_next = IDLE_W'(bit_val);
        end
      end
      default: state_next = S_INTEGRATE;
    endcase
  end

  // Run tracking is cleared in idle so the SOF bit opens a fresh run.
  always_ff @(posedge clk) begin
    if (!resetN || state_reg == S_IDLE) begin
      run_val <= 1'b0;
      run_len <= 3'd0;
    end else if (state_reg == S_ACTIVE && at_s2) begin
      if (!is_stuff && bit_val == run_val) begin
        run_len <= run_len + 3'd1;
      end else begin
        run_val <= bit_val;
        run_len <= 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      dout_reg      <= 1'b1;
      bit_valid_reg <= 1'b0;
    end else begin
      bit_valid_reg <= (state_reg == S_ACTIVE) && at_s2 && !is_stuff && !violation;
      if (state_reg == S_ACTIVE && at_s2 && !is_stuff) dout_reg <= bit_val;
    end
  end

`ifdef CAN_STUFF_ERR_EN
  logic stuff_err_reg;
  always_ff @(posedge clk) begin
    if (!resetN) stuff_err_reg <= 1'b0;
    else         stuff_err_reg <= violation && !bit_val;
  end
  assign stuffErr = stuff_err_reg;
`endif

  assign dOut        = dout_reg;
  assign bitValid    = bit_valid_reg;
  assign frameActive = (state_reg == S_ACTIVE);
  assign busIdle     = (state_reg == S_IDLE);
  assign samplePulse = (state_reg == S_ACTIVE) && !is_stuff && (at_s0 || at_s1 || at_s2);

endmodule

// File: tb/tb_can_bit_sampler.sv
// Directed bench for can_bit_sampler: per-bit vector table plus hand-written reset/timing sequences.
module tb_can_bit_sampler;

  logic clk = 1'b0;
  logic resetN;
  logic rxIn;
  logic dOut, samplePulse, frameActive, bitValid, busIdle;
`ifdef CAN_STUFF_ERR_EN
  logic stuffErr;
`endif

  int passed = 0;
  int total  = 0;

  can_bit_sampler dut (
    .clk         (clk),
    .resetN      (resetN),
    .rxIn        (rxIn),
    .dOut        (dOut),
    .samplePulse (samplePulse),
    .frameActive (frameActive),
    .bitValid    (bitValid),
    .busIdle     (busIdle)
`ifdef CAN_STUFF_ERR_EN
    ,
    .stuffErr    (stuffErr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rx;
    logic glitch;
    int   pulses;
    int   valids;
    logic dout;
    logic active;
    logic idle;
    int   serr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rx, input logic gl, input int p, input int v,
                              input logic d, input logic a, input logic i, input int se);
    vec_t t;
    t.rx = rx; t.glitch = gl; t.pulses = p; t.valids = v;
    t.dout = d; t.active = a; t.idle = i; t.serr = se;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // One bit window of 64 clk; the DUT's tq0 for this bit starts at iteration 3.
  task automatic run_bit(input logic val, input logic glitch,
                         output int np, output int nv, output int nse);
    np = 0; nv = 0; nse = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      rxIn = (glitch && i == 45) ? 1'b0 : val;
      @(negedge clk);
      if (samplePulse) np++;
      if (bitValid) nv++;
`ifdef CAN_STUFF_ERR_EN
      if (stuffErr) nse++;
`endif
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int np, nv, nse;
    int idle_rise, bad_dout, bad_act, n_pulse;
    int first_act, p_first, p_last, v_iter;
    logic d_at_valid;
    int id_bits;

    // Frame 1: SOF, ID 0x555, glitched recessive bit, stuffed zeros, dominant violation.
    add(0, 0, 3, 1, 0, 1, 0, 0);
    id_bits = 11'h555;
    for (int b = 10; b >= 0; b--) add(id_bits[b], 0, 3, 1, id_bits[b], 1, 0, 0);
    add(1, 1, 3, 1, 1, 1, 0, 0);
    for (int b = 0; b < 5; b++) add(0, 0, 3, 1, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 3, 1, 0, 1, 0, 0);
    for (int b = 0; b < 4; b++) add(0, 0, 3, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    for (int b = 0; b < 11; b++) add(1, 0, 0, 0, 0, 0, (b == 10), 0);
    // Frame 2: SOF, five recessive data bits, recessive violation (end of frame).
    add(0, 0, 3, 1, 0, 1, 0, 0);
    for (int b = 0; b < 5; b++) add(1, 0, 3, 1, 1, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0);
    for (int b = 0; b < 10; b++) add(1, 0, 0, 0, 1, 0, (b == 9), 0);

    resetN = 1'b0;
    rxIn   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dOut", int'(dOut), 1);
    check("rst_samplePulse", int'(samplePulse), 0);
    check("rst_frameActive", int'(frameActive), 0);
    check("rst_bitValid", int'(bitValid), 0);
    check("rst_busIdle", int'(busIdle), 0);
`ifdef CAN_STUFF_ERR_EN
    check("rst_stuffErr", int'(stuffErr), 0);
`endif

    // Idle integration from reset: 11th third sample at offset 688.
    @(posedge clk); #1;
    resetN = 1'b1;
    idle_rise = -1; bad_dout = 0; bad_act = 0; n_pulse = 0;
    for (int n = 0; n < 704; n++) begin
      @(negedge clk);
      if (busIdle && idle_rise < 0) idle_rise = n;
      if (dOut !== 1'b1) bad_dout++;
      if (frameActive !== 1'b0) bad_act++;
      if (samplePulse) n_pulse++;
    end
    $display("integrate: busIdle rose at offset %0d", idle_rise);
    check("t1_idle_rise", idle_rise, 689);
    check("t1_dout_not_1", bad_dout, 0);
    check("t1_active_high", bad_act, 0);
    check("t1_pulses", n_pulse, 0);
    check("t1_idle_end", int'(busIdle), 1);

    for (int k = 0; k < vecs.size(); k++) begin
      run_bit(vecs[k].rx, vecs[k].glitch, np, nv, nse);
      $display("vec %0d rx=%0d gl=%0d pulses=%0d valid=%0d dOut=%0d active=%0d idle=%0d",
               k, vecs[k].rx, vecs[k].glitch, np, nv, dOut, frameActive, busIdle);
      check($sformatf("v%0d_pulses", k), np, vecs[k].pulses);
      check($sformatf("v%0d_bitValid", k), nv, vecs[k].valids);
      check($sformatf("v%0d_dOut", k), int'(dOut), int'(vecs[k].dout));
      check($sformatf("v%0d_frameActive", k), int'(frameActive), int'(vecs[k].active));
      check($sformatf("v%0d_busIdle", k), int'(busIdle), int'(vecs[k].idle));
`ifdef CAN_STUFF_ERR_EN
      check($sformatf("v%0d_stuffErr", k), nse, vecs[k].serr);
`endif
    end

    // Frame 3: exact SOF timing, then reset mid-bit.
    first_act = -1; p_first = -1; p_last = -1; v_iter = -1; np = 0; d_at_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      rxIn = 1'b0;
      @(negedge clk);
      if (frameActive && first_act < 0) first_act = i;
      if (samplePulse) begin
        np++;
        if (p_first < 0) p_first = i;
        p_last = i;
      end
      if (bitValid) begin
        v_iter = i;
        d_at_valid = dOut;
      end
    end
    $display("sof: active@%0d pulses=%0d first@%0d last@%0d valid@%0d", first_act, np, p_first, p_last, v_iter);
    check("sof_active_iter", first_act, 3);
    check("sof_pulse_count", np, 3);
    check("sof_pulse_first", p_first, 43);
    check("sof_pulse_last", p_last, 51);
    check("sof_valid_iter", v_iter, 52);
    check("sof_dout", int'(d_at_valid), 0);

    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      rxIn = 1'b1;
      if (i == 44) resetN = 1'b0;
      @(negedge clk);
    end
    @(posedge clk); #1;
    resetN = 1'b1;
    @(negedge clk);
    $display("reset mid-frame: dOut=%0d active=%0d pulse=%0d valid=%0d idle=%0d",
             dOut, frameActive, samplePulse, bitValid, busIdle);
    check("mid_rst_dOut", int'(dOut), 1);
    check("mid_rst_frameActive", int'(frameActive), 0);
    check("mid_rst_samplePulse", int'(samplePulse), 0);
    check("mid_rst_bitValid", int'(bitValid), 0);
    check("mid_rst_busIdle", int'(busIdle), 0);
    n_pulse = 0; bad_act = 0; nv = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (samplePulse) n_pulse++;
      if (frameActive) bad_act++;
      if (bitValid) nv++;
    end
    check("post_rst_pulses", n_pulse, 0);
    check("post_rst_active", bad_act, 0);
    check("post_rst_valid", nv, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
